// File: rtl/npg_pkg.sv
// Shared widths, FSM state type and saturating amplitude helpers for the pulse sequencer.
package npg_pkg;

    localparam int unsigned FREQ_W = 12;
    localparam int unsigned PH_W   = 3;
    localparam int unsigned AMP_W  = 6;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned AMP_XW = AMP_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        POS,
        GAP,
        NEG
    } npg_state_e;

    // One guard bit so the sum can exceed the code range before clamping to the limit.
    function automatic logic [AMP_W-1:0] amp_sat_add(input logic [AMP_W-1:0]  amp,
                                                     input logic [STEP_W-1:0] step,
                                                     input logic [AMP_W-1:0]  lim);
        logic [AMP_XW-1:0] sum;
        sum = AMP_XW'(amp) + AMP_XW'(step);
        return (sum > AMP_XW'(lim)) ? lim : sum[AMP_W-1:0];
    endfunction

    function automatic logic [AMP_W-1:0] amp_sat_sub(input logic [AMP_W-1:0]  amp,
                                                     input logic [STEP_W-1:0] step,
                                                     input logic [AMP_W-1:0]  lim);
        logic [AMP_XW-1:0] dif;
        dif = AMP_XW'(amp) - AMP_XW'(step);
        if (dif[AMP_W]) begin
            dif = '0;
        end
        return (dif > AMP_XW'(lim)) ? lim : dif[AMP_W-1:0];
    endfunction

endpackage

// File: rtl/npg_pulse_sequencer_if.sv
// Configuration and current-driver bus of one stimulation channel.
interface npg_pulse_sequencer_if;
    import npg_pkg::*;

    logic              enable;
    logic [FREQ_W-1:0] freq;
    logic [PH_W-1:0]   phase_dur;
    logic [PH_W-1:0]   gap_dur;
    logic [AMP_W-1:0]  amp_target;
    logic [STEP_W-1:0] up;
    logic [STEP_W-1:0] down;
    logic [AMP_W-1:0]  dac_amp;
    logic              stim_pos;
    logic              stim_neg;
    logic              pulse_start;
    logic              overrun;
    logic              busy;

    modport master (
        output enable, freq, phase_dur, gap_dur, amp_target, up, down,
        input  dac_amp, stim_pos, stim_neg, pulse_start, overrun, busy
    );

    modport slave (
        input  enable, freq, phase_dur, gap_dur, amp_target, up, down,
        output dac_amp, stim_pos, stim_neg, pulse_start, overrun, busy
    );

endinterface

// File: rtl/npg_amp_ramp.sv
// Amplitude register with saturating ramp-up/ramp-down and ramp-down stop detection.
module npg_amp_ramp
    import npg_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              ramp_up_i,
    input  logic              ramp_down_i,
    input  logic              clear_i,
    input  logic [STEP_W-1:0] up_i,
    input  logic [STEP_W-1:0] down_i,
    input  logic [AMP_W-1:0]  target_i,
    output logic [AMP_W-1:0]  amp_o,
    output logic              stop_c_o
);

    logic [AMP_W-1:0] amp_q;
    logic [AMP_W-1:0] amp_d;

    // A zero up-step jumps straight to the plateau.
    always_comb begin
        amp_d = amp_q;
        if (clear_i) begin
            amp_d = '0;
        end else if (ramp_up_i) begin
            amp_d = (up_i == '0) ? target_i : amp_sat_add(amp_q, up_i, target_i);
        end else if (ramp_down_i) begin
            amp_d = amp_sat_sub(amp_q, down_i, target_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            amp_q <= '0;
        end else begin
            amp_q <= amp_d;
        end
    end

    assign amp_o    = amp_q;
    assign stop_c_o = (down_i == '0) || (AMP_XW'(amp_q) <= AMP_XW'(down_i));

endmodule

// File: rtl/npg_pulse_sequencer.sv
// Biphasic pulse sequencer for one stimulation channel with amplitude ramping.
// Define NPG_GAP_EN to insert an interphase gap of gap_dur+1 cycles between phases.
module npg_pulse_sequencer
    import npg_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    npg_pulse_sequencer_if.slave  bus
);

    npg_state_e        state_q, state_d;
    logic [FREQ_W-1:0] cnt_q, cnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              stopping_q, stopping_d;
    logic              stim_pos_q, stim_neg_q, pulse_start_q, overrun_q, busy_q;
    logic              start, ramp_up, ramp_down, amp_clr, overrun_d, wrap, stop_c;
    logic [AMP_W-1:0]  amp;
`ifdef NPG_GAP_EN
    logic [PH_W-1:0]   gap_q, gap_d;
`else
    logic              unused_gap;
    assign unused_gap = ^bus.gap_dur;
`endif

    assign wrap = (cnt_q == freq_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        freq_d     = freq_q;
        ph_d       = ph_q;
        phase_d    = phase_q;
        stopping_d = stopping_q;
`ifdef NPG_GAP_EN
        gap_d      = gap_q;
`endif
        start      = 1'b0;
        ramp_up    = 1'b0;
        ramp_down  = 1'b0;
        amp_clr    = 1'b0;
        overrun_d  = 1'b0;

        // Period counter free-runs modulo freq+1 whenever the channel is active.
        if (state_q != IDLE) begin
            stopping_d = ~bus.enable;
            cnt_d      = wrap ? '0 : cnt_q + FREQ_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    start   = 1'b1;
                    ramp_up = 1'b1;
                end
            end
            WAIT: begin
                if (wrap) begin
                    if (stopping_q && stop_c) begin
                        state_d = IDLE;
                        amp_clr = 1'b1;
                    end else begin
                        start     = 1'b1;
                        ramp_up   = ~stopping_q;
                        ramp_down = stopping_q;
                    end
                end
            end
            POS: begin
                overrun_d = wrap;
                if (ph_q == phase_q) begin
                    ph_d    = '0;
`ifdef NPG_GAP_EN
                    state_d = GAP;
`else
                    state_d = NEG;
`endif
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
`ifdef NPG_GAP_EN
            GAP: begin
                overrun_d = wrap;
                if (ph_q == gap_q) begin
                    ph_d    = '0;
                    state_d = NEG;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
`endif
            NEG: begin
                overrun_d = wrap;
                if (ph_q == phase_q) begin
                    ph_d    = '0;
                    state_d = WAIT;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pulse start: restart period and shadow the timing configuration.
        if (start) begin
            state_d = POS;
            cnt_d   = '0;
            ph_d    = '0;
            freq_d  = bus.freq;
            phase_d = bus.phase_dur;
`ifdef NPG_GAP_EN
            gap_d   = bus.gap_dur;
`endif
        end

        if (state_d == IDLE) begin
            cnt_d      = '0;
            ph_d       = '0;
            stopping_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            freq_q        <= '0;
            ph_q          <= '0;
            phase_q       <= '0;
            stopping_q    <= 1'b0;
`ifdef NPG_GAP_EN
            gap_q         <= '0;
`endif
            stim_pos_q    <= 1'b0;
            stim_neg_q    <= 1'b0;
            pulse_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            freq_q        <= freq_d;
            ph_q          <= ph_d;
            phase_q       <= phase_d;
            stopping_q    <= stopping_d;
`ifdef NPG_GAP_EN
            gap_q         <= gap_d;
`endif
            stim_pos_q    <= (state_d == POS);
            stim_neg_q    <= (state_d == NEG);
            pulse_start_q <= start;
            overrun_q     <= overrun_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    npg_amp_ramp u_amp_ramp (
        .clk         (clk),
        .resetn      (resetn),
        .ramp_up_i   (ramp_up),
        .ramp_down_i (ramp_down),
        .clear_i     (amp_clr),
        .up_i        (bus.up),
        .down_i      (bus.down),
        .target_i    (bus.amp_target),
        .amp_o       (amp),
        .stop_c_o    (stop_c)
    );

    assign bus.dac_amp     = amp;
    assign bus.stim_pos    = stim_pos_q;
    assign bus.stim_neg    = stim_neg_q;
    assign bus.pulse_start = pulse_start_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = busy_q;

endmodule
